// File: rtl/wb_cpl_tx.sv
// Completion transmitter: builds a 3DW CplD header, fetches the payload over Wishbone and streams 16-bit words to TX.
// Optional `WB_CPL_UR_EN: an unsupported request yields a data-less Cpl with UR status.
module wb_cpl_tx (
  input  logic        wb_clk,
  input  logic        rst,
  input  logic        cpl_req,
  input  logic [23:0] tran_id,
  input  logic [9:0]  tran_length,
  input  logic [7:0]  tran_be,
  input  logic [4:0]  tran_addr,
  input  logic [2:0]  tran_tc,
  input  logic [1:0]  tran_attr,
  input  logic [31:0] rd_adr,
  input  logic [15:0] completer_id,
  input  logic        cpl_ur,
  output logic        cpl_busy,
  output logic        cpl_done,
  output logic [15:0] dout,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_wen,
  input  logic        tx_full,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  state_t      state_q;
  logic [2:0]  hidx_q;
  logic [10:0] cnt_q;
  logic [23:0] tid_q;
  logic [9:0]  len_q;
  logic [2:0]  tc_q;
  logic [1:0]  attr_q;
  logic [15:0] cid_q;
  logic [11:0] bc_q;
  logic [6:0]  la_q;
  logic        ur_q;
  logic        busy_q, done_q, sop_q, eop_q, wen_q, cyc_q, stb_q;
  logic [15:0] dout_q;
  logic [31:0] adr_q;
  logic [2:0]  cti_q;

  logic [3:0]  fbe, lbe;
  logic [1:0]  fbe_lo, fbe_hi, lbe_hz;
  logic [12:0] bc_full;
  logic [11:0] bc_d;
  logic [6:0]  la_d;
  logic        ur_d;
  logic [15:0] hdr_word;
  logic [10:0] words_m1;
  logic        last_beat;

  assign fbe = tran_be[7:4];
  assign lbe = tran_be[3:0];

`ifdef WB_CPL_UR_EN
  assign ur_d = cpl_ur;
`else
  logic unused_ur;
  assign unused_ur = cpl_ur;
  assign ur_d = 1'b0;
`endif

  always_comb begin
    fbe_lo = 2'd0;
    if (fbe[0])      fbe_lo = 2'd0;
    else if (fbe[1]) fbe_lo = 2'd1;
    else if (fbe[2]) fbe_lo = 2'd2;
    else if (fbe[3]) fbe_lo = 2'd3;
    fbe_hi = 2'd0;
    if (fbe[3])      fbe_hi = 2'd3;
    else if (fbe[2]) fbe_hi = 2'd2;
    else if (fbe[1]) fbe_hi = 2'd1;
    lbe_hz = 2'd0;
    if (lbe[3])      lbe_hz = 2'd0;
    else if (lbe[2]) lbe_hz = 2'd1;
    else if (lbe[1]) lbe_hz = 2'd2;
    else if (lbe[0]) lbe_hz = 2'd3;
    // Length 0 means 1024 DW, so the 13-bit product reaches 4096 and truncates to 0.
    bc_full = {(tran_length == 10'd0), tran_length, 2'b00}
              - {11'd0, fbe_lo} - {11'd0, lbe_hz};
    if (tran_length == 10'd1)
      bc_d = (fbe == 4'd0) ? 12'd1 : {10'd0, fbe_hi} - {10'd0, fbe_lo} + 12'd1;
    else
      bc_d = bc_full[11:0];
    la_d = {tran_addr, fbe_lo};
  end

  always_comb begin
    hdr_word = 16'h0000;
    case (hidx_q)
      3'd0: hdr_word = {(ur_q ? 8'h0A : 8'h4A), 1'b0, tc_q, 4'h0};
      3'd1: hdr_word = {2'b00, attr_q, 2'b00, (ur_q ? 10'd0 : len_q)};
      3'd2: hdr_word = cid_q;
      3'd3: hdr_word = ur_q ? {3'b001, 1'b0, 12'd4} : {3'b000, 1'b0, bc_q};
      3'd4: hdr_word = tid_q[23:8];
      3'd5: hdr_word = {tid_q[7:0], 1'b0, la_q};
      default: hdr_word = 16'h0000;
    endcase
  end

  // 2*len-1 in 11 bits; len 0 wraps to 2047, i.e. 2048 beats.
  assign words_m1  = {len_q - 10'd1, 1'b1};
  assign last_beat = (cnt_q == words_m1);

  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hidx_q  <= 3'd0;
      cnt_q   <= 11'd0;
      tid_q   <= 24'd0;
      len_q   <= 10'd0;
      tc_q    <= 3'd0;
      attr_q  <= 2'd0;
      cid_q   <= 16'd0;
      bc_q    <= 12'd0;
      la_q    <= 7'd0;
      ur_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      wen_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      dout_q  <= 16'd0;
      adr_q   <= 32'd0;
      cti_q   <= 3'd0;
    end else begin
      wen_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpl_req) begin
            tid_q   <= tran_id;
            len_q   <= tran_length;
            tc_q    <= tran_tc;
            attr_q  <= tran_attr;
            cid_q   <= completer_id;
            bc_q    <= bc_d;
            la_q    <= la_d;
            ur_q    <= ur_d;
            adr_q   <= rd_adr;
            busy_q  <= 1'b1;
            hidx_q  <= 3'd0;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (!tx_full) begin
            dout_q <= hdr_word;
            wen_q  <= 1'b1;
            sop_q  <= (hidx_q == 3'd0);
            hidx_q <= hidx_q + 3'd1;
            if (hidx_q == 3'd5) begin
              if (ur_q) begin
                eop_q   <= 1'b1;
                state_q <= S_DONE;
              end else begin
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
                cti_q   <= 3'b000;
                cnt_q   <= 11'd0;
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (stb_q && wb_ack_i) begin
            dout_q <= {wb_dat_i[7:0], wb_dat_i[15:8]};
            wen_q  <= 1'b1;
            adr_q  <= adr_q + 32'd2;
            cnt_q  <= cnt_q + 11'd1;
            if (last_beat) begin
              eop_q   <= 1'b1;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              cti_q   <= 3'b000;
              state_q <= S_DONE;
            end else begin
              stb_q <= !tx_full;
              cti_q <= ((cnt_q + 11'd1) == words_m1) ? 3'b111 : 3'b000;
            end
          end else begin
            stb_q <= !tx_full;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpl_busy = busy_q;
  assign cpl_done = done_q;
  assign dout     = dout_q;
  assign dout_sop = sop_q;
  assign dout_eop = eop_q;
  assign dout_wen = wen_q;
  assign wb_adr_o = adr_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 2'b11;
  assign wb_cti_o = cti_q;

endmodule

// File: tb/tb_wb_cpl_tx.sv
// Bench for wb_cpl_tx: table of completion requests with hand-computed headers, plus stall and reset sequences.
module tb_wb_cpl_tx;

  logic        wb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpl_req = 1'b0;
  logic [23:0] tran_id = '0;
  logic [9:0]  tran_length = '0;
  logic [7:0]  tran_be = '0;
  logic [4:0]  tran_addr = '0;
  logic [2:0]  tran_tc = '0;
  logic [1:0]  tran_attr = '0;
  logic [31:0] rd_adr = '0;
  logic [15:0] completer_id = '0;
  logic        cpl_ur = 1'b0;
  logic        cpl_busy, cpl_done, dout_sop, dout_eop, dout_wen;
  logic [15:0] dout;
  logic        tx_full = 1'b0;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [1:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [15:0] wb_dat_i;

  wb_cpl_tx dut (
    .wb_clk(wb_clk), .rst(rst), .cpl_req(cpl_req), .tran_id(tran_id),
    .tran_length(tran_length), .tran_be(tran_be), .tran_addr(tran_addr),
    .tran_tc(tran_tc), .tran_attr(tran_attr), .rd_adr(rd_adr),
    .completer_id(completer_id), .cpl_ur(cpl_ur), .cpl_busy(cpl_busy),
    .cpl_done(cpl_done), .dout(dout), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_wen(dout_wen), .tx_full(tx_full), .wb_adr_o(wb_adr_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  always #5 wb_clk = ~wb_clk;

  function automatic logic [15:0] mem_f(input logic [31:0] a);
    if (a == 32'h10)      return 16'h1234;
    else if (a == 32'h12) return 16'h5678;
    else                  return a[15:0] ^ 16'h5AC3;
  endfunction

  assign wb_dat_i = mem_f(wb_adr_o);
  assign wb_ack_i = wb_cyc_o & wb_stb_o;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int fa = 0, fb = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(posedge wb_clk) begin
    #1;
    cyc_cnt = cyc_cnt + 1;
    tx_full = (fa > 0 && cyc_cnt >= fa && cyc_cnt < fa + 3) ||
              (fb > 0 && cyc_cnt >= fb && cyc_cnt < fb + 3);
  end

  logic [15:0] got_q[$];
  bit          sop_q[$], eop_q[$];
  logic [31:0] adr_q[$];
  logic [2:0]  cti_q[$];
  int sop_cyc, eop_cyc, last_hdr_cyc, done_cnt, done_cyc, stb_viol, hdr_viol, widx;
  bit cyc_seen, full_prev;

  always @(negedge wb_clk) begin
    if (dout_wen) begin
      got_q.push_back(dout);
      sop_q.push_back(dout_sop);
      eop_q.push_back(dout_eop);
      if (widx == 0) sop_cyc = cyc_cnt;
      if (widx == 5) last_hdr_cyc = cyc_cnt;
      if (widx < 6 && full_prev) hdr_viol++;
      if (dout_eop) eop_cyc = cyc_cnt;
      widx++;
    end
    if (wb_cyc_o) cyc_seen = 1'b1;
    if (wb_cyc_o && wb_stb_o) begin
      adr_q.push_back(wb_adr_o);
      cti_q.push_back(wb_cti_o);
      if (full_prev) stb_viol++;
    end
    if (cpl_done) begin
      done_cnt++;
      done_cyc = cyc_cnt;
    end
    full_prev = tx_full;
  end

  typedef struct {
    logic [9:0]  len;
    logic [7:0]  be;
    logic [23:0] tid;
    logic [4:0]  addr;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [31:0] rd;
    logic [15:0] cid;
    logic        ur;
    int          fa_off;
    int          fb_off;
    logic [95:0] hw;
    int          nw;
  } vec_t;

  function automatic vec_t mkv(input logic [9:0] len, input logic [7:0] be, input logic [23:0] tid,
                               input logic [4:0] addr, input logic [2:0] tc, input logic [1:0] attr,
                               input logic [31:0] rd, input logic [15:0] cid, input logic ur,
                               input int fo, input int fbo, input logic [95:0] hw, input int nw);
    vec_t v;
    v.len = len; v.be = be; v.tid = tid; v.addr = addr; v.tc = tc; v.attr = attr;
    v.rd = rd; v.cid = cid; v.ur = ur; v.fa_off = fo; v.fb_off = fbo; v.hw = hw; v.nw = nw;
    return v;
  endfunction

  task automatic clear_mon();
    got_q.delete(); sop_q.delete(); eop_q.delete(); adr_q.delete(); cti_q.delete();
    widx = 0; done_cnt = 0; stb_viol = 0; hdr_viol = 0; cyc_seen = 1'b0;
    sop_cyc = -1; eop_cyc = -1; last_hdr_cyc = -1; done_cyc = -1;
  endtask

  task automatic launch(input vec_t v, output int req_cyc);
    @(posedge wb_clk); #2;
    tran_id = v.tid; tran_length = v.len; tran_be = v.be; tran_addr = v.addr;
    tran_tc = v.tc; tran_attr = v.attr; rd_adr = v.rd; completer_id = v.cid; cpl_ur = v.ur;
    clear_mon();
    cpl_req = 1'b1;
    req_cyc = cyc_cnt;
    fa = (v.fa_off > 0) ? req_cyc + v.fa_off : 0;
    fb = (v.fb_off > 0) ? req_cyc + v.fb_off : 0;
    @(posedge wb_clk); #2;
    cpl_req = 1'b0;
  endtask

  task automatic run_txn(input int id, input vec_t v);
    int rc, bad_dat, bad_flag, bad_bus;
    logic [15:0] e;
    launch(v, rc);
    @(negedge wb_clk);
    chk($sformatf("v%0d_busy", id), {31'd0, cpl_busy}, 32'd1);
    for (int k = 0; k < 6000 && done_cnt == 0; k++) @(negedge wb_clk);
    chk($sformatf("v%0d_done_seen", id), done_cnt, 32'd1);
    repeat (2) @(negedge wb_clk);
    fa = 0; fb = 0;
    chk($sformatf("v%0d_done_once", id), done_cnt, 32'd1);
    chk($sformatf("v%0d_busy_end", id), {31'd0, cpl_busy}, 32'd0);
    chk($sformatf("v%0d_nwords", id), got_q.size(), 6 + v.nw);
    for (int i = 0; i < 6; i++) begin
      e = v.hw[95 - 16*i -: 16];
      chk($sformatf("v%0d_W%0d", id, i), (got_q.size() > i) ? {16'd0, got_q[i]} : 32'hDEAD_0000, {16'd0, e});
    end
    bad_dat = 0; bad_flag = 0; bad_bus = 0;
    for (int i = 0; i < v.nw && 6 + i < got_q.size(); i++) begin
      e = mem_f(v.rd + 32'(2*i));
      if (got_q[6+i] !== {e[7:0], e[15:8]}) bad_dat++;
    end
    for (int i = 0; i < got_q.size(); i++) begin
      if (sop_q[i] != (i == 0)) bad_flag++;
      if (eop_q[i] != (i == 6 + v.nw - 1)) bad_flag++;
    end
    if (adr_q.size() != v.nw) bad_bus++;
    for (int i = 0; i < adr_q.size() && i < v.nw; i++) begin
      if (adr_q[i] !== v.rd + 32'(2*i)) bad_bus++;
      if (cti_q[i] !== ((i == v.nw - 1) ? 3'b111 : 3'b000)) bad_bus++;
    end
    chk($sformatf("v%0d_data_bad", id), bad_dat, 32'd0);
    chk($sformatf("v%0d_sop_eop_bad", id), bad_flag, 32'd0);
    chk($sformatf("v%0d_bus_bad", id), bad_bus, 32'd0);
    chk($sformatf("v%0d_cyc_seen", id), {31'd0, cyc_seen}, {31'd0, v.nw != 0});
    chk($sformatf("v%0d_done_after_eop", id), done_cyc, eop_cyc + 1);
    chk($sformatf("v%0d_stb_while_full", id), stb_viol, 32'd0);
    chk($sformatf("v%0d_hdr_while_full", id), hdr_viol, 32'd0);
    if (v.fa_off == 0 && v.fb_off == 0) begin
      chk($sformatf("v%0d_latency", id), sop_cyc, rc + 2);
      chk($sformatf("v%0d_hdr_contig", id), last_hdr_cyc, sop_cyc + 5);
    end
  endtask

  vec_t tbl[8];

  initial begin
    int rc;
    tbl[0] = mkv(10'd1, 8'hF0, 24'h020005, 5'd4, 3'd0, 2'd0, 32'h10, 16'h0100, 1'b0, 0, 0,
                 {16'h4A00, 16'h0001, 16'h0100, 16'h0004, 16'h0200, 16'h0510}, 2);
    tbl[1] = mkv(10'd2, 8'hE3, 24'hABCD12, 5'h1F, 3'd5, 2'd2, 32'h2000, 16'h1234, 1'b0, 0, 0,
                 {16'h4A50, 16'h2002, 16'h1234, 16'h0005, 16'hABCD, 16'h127D}, 4);
    tbl[2] = mkv(10'd1, 8'h60, 24'h000000, 5'd0, 3'd7, 2'd3, 32'h100, 16'hFFFF, 1'b0, 0, 0,
                 {16'h4A70, 16'h3001, 16'hFFFF, 16'h0002, 16'h0000, 16'h0001}, 2);
    tbl[3] = mkv(10'd1, 8'h00, 24'h123456, 5'd3, 3'd1, 2'd1, 32'h4, 16'h0008, 1'b0, 0, 0,
                 {16'h4A10, 16'h1001, 16'h0008, 16'h0001, 16'h1234, 16'h560C}, 2);
    tbl[4] = mkv(10'd3, 8'hFF, 24'h00FF80, 5'd2, 3'd0, 2'd0, 32'h8000, 16'h0200, 1'b0, 4, 13,
                 {16'h4A00, 16'h0003, 16'h0200, 16'h000C, 16'h00FF, 16'h8008}, 6);
    tbl[5] = mkv(10'd4, 8'h81, 24'h777701, 5'h10, 3'd0, 2'd0, 32'h30, 16'h0A0B, 1'b0, 0, 0,
                 {16'h4A00, 16'h0004, 16'h0A0B, 16'h000A, 16'h7777, 16'h0143}, 8);
    tbl[6] = mkv(10'd0, 8'hFF, 24'h010203, 5'd0, 3'd0, 2'd0, 32'h0, 16'h0001, 1'b0, 0, 0,
                 {16'h4A00, 16'h0000, 16'h0001, 16'h0000, 16'h0102, 16'h0300}, 2048);
`ifdef WB_CPL_UR_EN
    tbl[7] = mkv(10'd2, 8'hFF, 24'h445566, 5'd1, 3'd0, 2'd0, 32'h40, 16'h0C0D, 1'b1, 0, 0,
                 {16'h0A00, 16'h0000, 16'h0C0D, 16'h2004, 16'h4455, 16'h6604}, 0);
`else
    tbl[7] = mkv(10'd2, 8'hFF, 24'h445566, 5'd1, 3'd0, 2'd0, 32'h40, 16'h0C0D, 1'b1, 0, 0,
                 {16'h4A00, 16'h0002, 16'h0C0D, 16'h0008, 16'h4455, 16'h6604}, 4);
`endif

    clear_mon();
    repeat (3) @(negedge wb_clk);
    chk("rst_busy", {31'd0, cpl_busy}, 32'd0);
    chk("rst_done", {31'd0, cpl_done}, 32'd0);
    chk("rst_wen_sop_eop", {29'd0, dout_wen, dout_sop, dout_eop}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_cti", {29'd0, wb_cti_o}, 32'd0);
    chk("tied_we_sel", {29'd0, wb_we_o, wb_sel_o}, 32'd3);
    @(posedge wb_clk); #2;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(i, tbl[i]);

    // Reset while the third payload beat is on the bus.
    launch(tbl[5], rc);
    for (int k = 0; k < 100 && adr_q.size() < 3; k++) begin
      @(negedge wb_clk); #1;
    end
    chk("rst_mid_beat3_reached", adr_q.size(), 32'd3);
    rst = 1'b1;
    @(negedge wb_clk); #1;
    chk("rst_mid_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst_mid_busy_wen", {30'd0, cpl_busy, dout_wen}, 32'd0);
    @(negedge wb_clk); #1;
    chk("rst_mid_words", got_q.size(), 32'd8);
    chk("rst_mid_dout_adr", {dout, wb_adr_o[15:0]}, 32'd0);
    @(posedge wb_clk); #2;
    rst = 1'b0;
    run_txn(10, tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
